// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM duty sequencer: default geometry and FSM state encoding.
package pwm_seq_pkg;

    localparam int STEPS_DEF   = 10;
    localparam int DUTY_W_DEF  = 4;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        DWELL  = 2'd2,
        FINISH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty request channel (valid/ready) carrying the requested level and step dwell.
interface pwm_duty_sequencer_if
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);

    logic               tgt_valid;
    logic               tgt_ready;
    logic [DUTY_W-1:0]  tgt_duty;
    logic [DWELL_W-1:0] dwell;

    modport master (output tgt_valid, output tgt_duty, output dwell, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_duty, input dwell, output tgt_ready);

endinterface

// File: rtl/pwm_seq_dwell_timer.sv
// Dwell down-counter: load with a start value, count while enabled, expire at terminal count zero.
module pwm_seq_dwell_timer
    import pwm_seq_pkg::*;
#(
    parameter int W = DWELL_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps an external pwm_gen to a requested duty level with inc/dec pulses spaced by a dwell.
// Optional emergency ramp-down input estop is built in when PWM_SEQ_ESTOP_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request, tgt_ready high
// STEP   | one inc/dec pulse, shadow count moves by one
// DWELL  | idle gap of dwell cycles between steps
// FINISH | done pulse, then back to IDLE
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int STEPS   = STEPS_DEF,
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef PWM_SEQ_ESTOP_EN
    input  logic                 estop,
`endif
    pwm_duty_sequencer_if.slave  tgt,
    output logic                 inc_duty,
    output logic                 dec_duty,
    output logic [DUTY_W-1:0]    cur_duty,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_STEP   = STEP;
    localparam logic [1:0] ST_DWELL  = DWELL;
    localparam logic [1:0] ST_FINISH = FINISH;
    localparam logic [DUTY_W-1:0] MAX_DUTY = DUTY_W'(STEPS);

    logic [1:0]         state;
    logic [DUTY_W-1:0]  target_q;
    logic [DUTY_W-1:0]  eff_target;
    logic [DUTY_W-1:0]  req_duty;
    logic [DUTY_W-1:0]  next_duty;
    logic [DWELL_W-1:0] dwell_q;
    logic               accept;
    logic               up;
    logic               at_target;
    logic               skip_dwell;
    logic               tmr_load;
    logic               tmr_expire;

`ifdef PWM_SEQ_ESTOP_EN
    // Set once an estop ramp has reached 0, so a held estop does not retrigger.
    logic estop_seen;
`endif

    always_comb begin
        eff_target = target_q;
        skip_dwell = (dwell_q == '0);
`ifdef PWM_SEQ_ESTOP_EN
        if (estop) begin
            eff_target = '0;
            skip_dwell = 1'b1;
        end
`endif
    end

    assign req_duty  = (tgt.tgt_duty > MAX_DUTY) ? MAX_DUTY : tgt.tgt_duty;
    assign at_target = (cur_duty == eff_target);
    assign up        = (eff_target > cur_duty);
    assign next_duty = up ? cur_duty + DUTY_W'(1) : cur_duty - DUTY_W'(1);

`ifdef PWM_SEQ_ESTOP_EN
    assign tgt.tgt_ready = (state == ST_IDLE) && !estop;
`else
    assign tgt.tgt_ready = (state == ST_IDLE);
`endif

    assign accept   = tgt.tgt_valid && tgt.tgt_ready;
    assign inc_duty = (state == ST_STEP) && !at_target && up;
    assign dec_duty = (state == ST_STEP) && !at_target && !up;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FINISH);
    assign tmr_load = (state == ST_STEP) && !at_target && (next_duty != eff_target) && !skip_dwell;

    pwm_seq_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (dwell_q - DWELL_W'(1)),
        .count    (state == ST_DWELL),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_duty <= '0;
            target_q <= '0;
            dwell_q  <= '0;
`ifdef PWM_SEQ_ESTOP_EN
            estop_seen <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target_q <= req_duty;
                        dwell_q  <= tgt.dwell;
                        state    <= (req_duty == cur_duty) ? ST_FINISH : ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (at_target) begin
                        state <= ST_FINISH;
                    end else begin
                        cur_duty <= next_duty;
                        if (next_duty == eff_target) begin
                            state <= ST_FINISH;
                        end else if (skip_dwell) begin
                            state <= ST_STEP;
                        end else begin
                            state <= ST_DWELL;
                        end
                    end
                end
                ST_DWELL: begin
                    if (tmr_expire || skip_dwell) begin
                        state <= ST_STEP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef PWM_SEQ_ESTOP_EN
            if (estop) begin
                target_q <= '0;
            end
            if ((state == ST_IDLE) && estop && !estop_seen) begin
                state <= at_target ? ST_FINISH : ST_STEP;
            end
            estop_seen <= estop && (estop_seen || ((state == ST_FINISH) && (cur_duty == '0)));
`endif
        end
    end

endmodule
